// File: rtl/seq_addsub_div.sv
// seq_addsub_div: non-restoring unsigned divider with start/done handshake; DIVZERO_DET_EN enables the divide-by-zero shortcut
module seq_addsub_div #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         dz
);
    localparam int cw = $clog2(n + 1);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, next_state;
    logic [n:0] p, sp, p_step, d_ext;
    logic [n-1:0] q, d, rem_fix;
    logic [cw-1:0] cnt;
    logic zero_hit;
`ifdef DIVZERO_DET_EN
    assign zero_hit = divisor == '0;
`else
    assign zero_hit = 1'b0;
    assign dz = 1'b0;
`endif
    assign d_ext = {1'b0, d};
    assign sp = {p[n-1:0], q[n-1]};
    assign p_step = p[n] ? sp + d_ext : sp - d_ext;
    // final restore only touches the low n bits; the restored P is never negative
    assign rem_fix = p[n] ? p[n-1:0] + d : p[n-1:0];
    always_ff @(posedge clk) state <= rst ? IDLE : next_state;
    always_comb begin
        next_state = (state == IDLE) ? ((start && !zero_hit) ? ITER : IDLE) :
                     (state == ITER) ? ((cnt == cw'(1)) ? FIX : ITER) : IDLE;
    end
    always_comb busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
            q <= '0;
            d <= '0;
            cnt <= '0;
            done <= 1'b0;
            quotient <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start && zero_hit) begin
                quotient <= '1;
                remainder <= dividend;
                done <= 1'b1;
            end else if (state == IDLE && start) begin
                p <= '0;
                q <= dividend;
                d <= divisor;
                cnt <= cw'(n);
            end else if (state == ITER) begin
                p <= p_step;
                q <= {q[n-2:0], ~p_step[n]};
                cnt <= cnt - cw'(1);
            end else if (state == FIX) begin
                p <= {1'b0, rem_fix};
                quotient <= q;
                remainder <= rem_fix;
                done <= 1'b1;
            end
        end
    end
`ifdef DIVZERO_DET_EN
    always_ff @(posedge clk) begin
        if (rst)
            dz <= 1'b0;
        else if (state == IDLE && start && zero_hit)
            dz <= 1'b1;
        else if (state == FIX)
            dz <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_seq_addsub_div.sv
// tb_seq_addsub_div: directed vectors plus reference sweep for seq_addsub_div at n=8 and n=16
module tb_seq_addsub_div;
`ifdef DIVZERO_DET_EN
    localparam bit det = 1'b1;
`else
    localparam bit det = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0, quotient, remainder;
    logic busy, done, dz;
    logic start16 = 1'b0;
    logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;
    logic busy16, done16, dz16;
    int vectors = 0;
    int miscompares = 0;

    seq_addsub_div #(.n(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
    );
    seq_addsub_div #(.n(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dividend16), .divisor(divisor16),
        .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16), .dz(dz16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input bit spur);
        int lat, bc, elat;
        logic ez;
        ez = det && b == 8'd0;
        elat = ez ? 0 : 9;
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            if (spur && (lat == 2 || lat == 4)) begin
                start = 1'b1;
                dividend = 8'd50;
                divisor = 8'd3;
            end else
                start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".dz"}, dz, ez);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".busy_cycles"}, bc, elat);
        chk({tag, ".busy_at_done"}, busy, 0);
    endtask

    task automatic div16(input logic [15:0] a, input logic [15:0] b);
        int lat;
        logic ez;
        ez = det && b == 16'd0;
        start16 = 1'b1;
        dividend16 = a;
        divisor16 = b;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("sweep16.quotient", quotient16, b == 0 ? 16'hffff : a / b);
        chk("sweep16.remainder", remainder16, b == 0 ? a : a % b);
        chk("sweep16.dz", dz16, ez);
        chk("sweep16.latency", lat, ez ? 0 : 17);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dones;
        logic [7:0] a, b;
        logic [15:0] a16, b16;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.dz", dz, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        div8("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        div8("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        div8("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        div8("d200_200", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0);
        div8("d200_0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        div8("busy_start", 8'd100, 8'd7, 8'd14, 8'd2, 1'b1);
        div8("start_on_done", 8'd60, 8'd8, 8'd7, 8'd4, 1'b0);
        @(posedge clk);
        #1;
        chk("done_cleared", done, 0);
        start = 1'b1;
        dividend = 8'd100;
        divisor = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.quotient", quotient, 0);
        chk("midrst.remainder", remainder, 0);
        chk("midrst.dz", dz, 0);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        chk("midrst.no_activity", dones, 0);
        div8("after_rst", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(255, 0));
            b = ($urandom_range(15, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
            div8("sweep8", a, b, b == 0 ? 8'hff : a / b, b == 0 ? a : a % b, 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom_range(65535, 0));
            b16 = ($urandom_range(15, 0) == 0) ? 16'd0 :
                  ($urandom_range(1, 0) == 0) ? 16'($urandom_range(255, 1)) : 16'($urandom_range(65535, 1));
            div16(a16, b16);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
